// File: rtl/imm_pkg.sv
// Shared constants for the immediate-extension stage: default widths, mode
// encodings and the skid-buffer occupancy states.
package imm_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_IMM_WIDTH  = 16;
  localparam int unsigned DEF_JUMP_WIDTH = 26;
  localparam int unsigned DEF_MODE_WIDTH = 3;

  // Buffered payload is {illegal, target, imm}
  localparam int unsigned PAYLOAD_W = 2 * DEF_DATA_WIDTH + 1;

  localparam int unsigned MODE_SIGN   = 0;
  localparam int unsigned MODE_ZERO   = 1;
  localparam int unsigned MODE_LUI    = 2;
  localparam int unsigned MODE_BRANCH = 3;
  localparam int unsigned MODE_JUMP   = 4;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Valid/ready payload bus between decode and the immediate-extension stage.
interface imm_extend_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MODE_WIDTH = 3
) ();

  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_instruccion;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [MODE_WIDTH-1:0] i_mode;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_imm;
  logic [DATA_WIDTH-1:0] o_target;
  logic                  o_illegal;

  modport master (
    output i_valid, i_instruccion, i_pc, i_mode, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_target, o_illegal
  );

  modport slave (
    input  i_valid, i_instruccion, i_pc, i_mode, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_target, o_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extension and branch/jump target computation.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IMM_WIDTH  = DEF_IMM_WIDTH,
  parameter int unsigned JUMP_WIDTH = DEF_JUMP_WIDTH,
  parameter int unsigned MODE_WIDTH = DEF_MODE_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [MODE_WIDTH-1:0] i_mode,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [DATA_WIDTH-1:0] o_target,
  output logic                  o_illegal
);

  localparam int unsigned EXT_W  = DATA_WIDTH - IMM_WIDTH;
  localparam int unsigned JEXT_W = DATA_WIDTH - JUMP_WIDTH;

  logic [IMM_WIDTH-1:0]  imm;
  logic [DATA_WIDTH-1:0] sext;
  logic [DATA_WIDTH-1:0] zext;
  logic [DATA_WIDTH-1:0] lui;
  logic [DATA_WIDTH-1:0] boff;
  logic [DATA_WIDTH-1:0] btgt;
  logic [DATA_WIDTH-1:0] jidx;
  logic [DATA_WIDTH-1:0] jtgt;
  logic                  unused_instr;

  assign imm  = i_instr[IMM_WIDTH-1:0];
  assign sext = {{EXT_W{imm[IMM_WIDTH-1]}}, imm};
  assign zext = {{EXT_W{1'b0}}, imm};
  assign lui  = {imm, {EXT_W{1'b0}}};
  assign boff = {sext[DATA_WIDTH-3:0], 2'b00};
  assign btgt = i_pc + boff;
  assign jidx = {{JEXT_W{1'b0}}, i_instr[JUMP_WIDTH-1:0]};

  // Bits above both fields are opcode/register fields decoded elsewhere
  assign unused_instr = ^i_instr;

  // Jump keeps the PC region bits above the shifted index
  generate
    if (JUMP_WIDTH + 2 < DATA_WIDTH) begin : g_jtgt_region
      assign jtgt = {i_pc[DATA_WIDTH-1:JUMP_WIDTH+2], i_instr[JUMP_WIDTH-1:0], 2'b00};
    end else begin : g_jtgt_full
      assign jtgt = {i_instr[JUMP_WIDTH-1:0], 2'b00};
    end
  endgenerate

  always_comb begin
    o_imm     = sext;
    o_target  = '0;
    o_illegal = 1'b0;
    case (i_mode)
      MODE_WIDTH'(MODE_SIGN):   o_imm = sext;
      MODE_WIDTH'(MODE_ZERO):   o_imm = zext;
      MODE_WIDTH'(MODE_LUI):    o_imm = lui;
      MODE_WIDTH'(MODE_BRANCH): begin
        o_imm    = boff;
        o_target = btgt;
      end
      MODE_WIDTH'(MODE_JUMP): begin
        o_imm    = jidx;
        o_target = jtgt;
      end
      default:                  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer so that
// execute stalls never drop a decoded instruction.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IMM_WIDTH  = DEF_IMM_WIDTH,
  parameter int unsigned JUMP_WIDTH = DEF_JUMP_WIDTH,
  parameter int unsigned MODE_WIDTH = DEF_MODE_WIDTH
) (
  input logic               i_clk,
  input logic               i_reset,
  imm_extend_stage_if.slave bus
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] dec_imm;
  logic [DATA_WIDTH-1:0] dec_target;
  logic                  dec_illegal;
  logic [PW-1:0]         dec_payload;

  buf_state_e    state_q, state_d;
  logic [PW-1:0] out_q, out_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          in_xfer;
  logic          out_xfer;

  imm_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .JUMP_WIDTH (JUMP_WIDTH),
    .MODE_WIDTH (MODE_WIDTH)
  ) u_decode (
    .i_instr   (bus.i_instruccion),
    .i_pc      (bus.i_pc),
    .i_mode    (bus.i_mode),
    .o_imm     (dec_imm),
    .o_target  (dec_target),
    .o_illegal (dec_illegal)
  );

  assign dec_payload = {dec_illegal, dec_target, dec_imm};
  assign in_xfer     = bus.i_valid & ready_q;
  assign out_xfer    = valid_q & bus.i_ready;

  // Occupancy update: OUT drives the bus, SKID catches a beat while stalled
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.i_flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_xfer) begin
            out_d   = dec_payload;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = dec_payload;
            state_d = BUF_FULL;
          end else if (in_xfer && out_xfer) begin
            out_d   = dec_payload;
          end else if (out_xfer) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_xfer) begin
            out_d   = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    valid_d = (state_d != BUF_EMPTY);
    ready_d = (state_d != BUF_FULL);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= BUF_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_ready   = ready_q;
  assign bus.o_imm     = out_q[DATA_WIDTH-1:0];
  assign bus.o_target  = out_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.o_illegal = out_q[PW-1];

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed vectors, backpressure,
// flush and async-reset sequences, plus random traffic against a queue model.
module tb_imm_extend_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  imm_extend_stage_if #(.DATA_WIDTH(32), .MODE_WIDTH(3)) bus ();

  imm_extend_stage #(
    .DATA_WIDTH (32),
    .IMM_WIDTH  (16),
    .JUMP_WIDTH (26),
    .MODE_WIDTH (3)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  mode;
    logic [31:0] exp_imm;
    logic [31:0] exp_tgt;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [2:0] mode);
    bus.i_valid       = v;
    bus.i_instruccion = instr;
    bus.i_pc          = pc;
    bus.i_mode        = mode;
  endtask

  // Reference decode from the arithmetic definition of each mode
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [2:0] mode);
    exp_t        r;
    longint      u16;
    longint      sv;
    longint      idx;
    u16   = longint'(instr) % 65536;
    sv    = (u16 >= 32768) ? u16 - 65536 : u16;
    idx   = longint'(instr) % 67108864;
    r.imm = 32'(sv);
    r.tgt = 32'd0;
    r.ill = 1'b0;
    case (mode)
      3'd0: r.imm = 32'(sv);
      3'd1: r.imm = 32'(u16);
      3'd2: r.imm = 32'(u16 * 65536);
      3'd3: begin
        r.imm = 32'(sv * 4);
        r.tgt = 32'(longint'(pc) + sv * 4);
      end
      3'd4: begin
        r.imm = 32'(idx);
        r.tgt = (pc & 32'hF000_0000) | 32'(idx * 4);
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  vec_t vecs[9];
  exp_t e;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0);

    vecs[0] = '{32'h0000_8004, 32'h0000_0000, 3'd0, 32'hFFFF_8004, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h3C01_F0F0, 32'h0040_0004, 3'd1, 32'h0000_F0F0, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h3C01_F0F0, 32'h0040_0004, 3'd2, 32'hF0F0_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h3C01_F0F0, 32'h0040_0004, 3'd4, 32'h0001_F0F0, 32'h0007_C3C0, 1'b0};
    vecs[4] = '{32'h0000_FFFF, 32'h0000_0000, 3'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[5] = '{32'h0000_8004, 32'h1234_5678, 3'd6, 32'hFFFF_8004, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h1234_7FFF, 32'h0000_0000, 3'd0, 32'h0000_7FFF, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_0010, 32'h0040_0004, 3'd3, 32'h0000_0040, 32'h0040_0044, 1'b0};
    vecs[8] = '{32'hAB00_1234, 32'h9000_0000, 3'd7, 32'h0000_1234, 32'h0000_0000, 1'b1};

    // Reset values while reset is held
    #12;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_imm", bus.o_imm, 32'd0);
    check("rst_target", bus.o_target, 32'd0);
    check("rst_illegal", 32'(bus.o_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus.o_ready), 32'd1);
    check("post_rst_valid", 32'(bus.o_valid), 32'd0);

    // Directed vectors, one beat each with downstream ready
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].mode);
      tick();
      drive(1'b0, 32'd0, 32'd0, 3'd0);
      check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'd1);
      check($sformatf("vec%0d_imm", i), bus.o_imm, vecs[i].exp_imm);
      check($sformatf("vec%0d_target", i), bus.o_target, vecs[i].exp_tgt);
      check($sformatf("vec%0d_illegal", i), 32'(bus.o_illegal), 32'(vecs[i].exp_ill));
      tick();
      check($sformatf("vec%0d_drain", i), 32'(bus.o_valid), 32'd0);
    end

    // Backpressure: three beats with downstream stalled
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h0000_8001, 32'd0, 3'd0);
    tick();
    check("bp_ready_after_1", 32'(bus.o_ready), 32'd1);
    check("bp_imm_a", bus.o_imm, 32'hFFFF_8001);
    drive(1'b1, 32'h0000_8002, 32'd0, 3'd1);
    tick();
    check("bp_ready_after_2", 32'(bus.o_ready), 32'd0);
    check("bp_hold_a", bus.o_imm, 32'hFFFF_8001);
    drive(1'b1, 32'h0000_8003, 32'd0, 3'd2);
    tick();
    tick();
    check("bp_ready_stall", 32'(bus.o_ready), 32'd0);
    check("bp_valid_stall", 32'(bus.o_valid), 32'd1);
    check("bp_hold_a2", bus.o_imm, 32'hFFFF_8001);
    bus.i_ready = 1'b1;
    tick();
    check("bp_imm_b", bus.o_imm, 32'h0000_8002);
    check("bp_ready_reopen", 32'(bus.o_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check("bp_imm_c", bus.o_imm, 32'h8003_0000);
    check("bp_valid_c", 32'(bus.o_valid), 32'd1);
    tick();
    check("bp_drained", 32'(bus.o_valid), 32'd0);

    // Flush while FULL with a simultaneous input beat
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h0000_0011, 32'd0, 3'd0);
    tick();
    drive(1'b1, 32'h0000_0022, 32'd0, 3'd0);
    tick();
    check("fl_full_ready", 32'(bus.o_ready), 32'd0);
    drive(1'b1, 32'h0000_0033, 32'd0, 3'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check("fl_valid", 32'(bus.o_valid), 32'd0);
    check("fl_ready", 32'(bus.o_ready), 32'd1);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fl_no_ghost%0d", k), 32'(bus.o_valid), 32'd0);
    end

    // Async reset between clock edges while a beat is held
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h0000_ABCD, 32'd0, 3'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check("ar_pre_valid", 32'(bus.o_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.o_valid), 32'd0);
    check("ar_imm", bus.o_imm, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    check("ar_ready", 32'(bus.o_ready), 32'd1);
    check("ar_valid_after", 32'(bus.o_valid), 32'd0);

    // Random traffic against a FIFO-occupancy model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic        v;
      logic        rdy;
      logic        fl;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  mode;
      check("rnd_valid", 32'(bus.o_valid), 32'(q.size() > 0));
      check("rnd_ready", 32'(bus.o_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        check("rnd_imm", bus.o_imm, q[0].imm);
        check("rnd_target", bus.o_target, q[0].tgt);
        check("rnd_illegal", 32'(bus.o_illegal), 32'(q[0].ill));
      end
      v     = 1'($urandom_range(0, 3) != 0);
      rdy   = 1'($urandom_range(0, 2) != 0);
      fl    = 1'($urandom_range(0, 40) == 0);
      instr = $urandom;
      pc    = $urandom;
      mode  = 3'($urandom_range(0, 7));
      drive(v, instr, pc, mode);
      bus.i_ready = rdy;
      bus.i_flush = fl;
      if (fl) begin
        q.delete();
      end else begin
        logic in_fire;
        in_fire = v && (q.size() < 2);
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (in_fire) begin
          e = ref_decode(instr, pc, mode);
          q.push_back(e);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
